// File: rtl/stream_demuxf8_1to2.sv
// ---------------------------------------------------------------------------
// stream_demuxf8_1to2
//
// Registered 1-to-2 valid/ready stream demultiplexer. Each input beat is
// steered to channel 0 or channel 1 by S. Each channel has its own one-entry
// holding register, so a stalled consumer only blocks beats aimed at that
// channel. Per-channel delivered-beat counters are provided for debug.
//
// Ports:
//   C                  clock, rising edge
//   RST_N              synchronous active-low reset
//   I, S, I_VALID      input beat, route select, beat present
//   I_READY            input beat accepted this cycle (combinational)
//   O0/O1              channel data (registered)
//   O0_VALID/O1_VALID  channel holds a beat
//   O0_READY/O1_READY  downstream consumer accepts
//   CLR_CNT            synchronous clear of both counters
//   CNT0/CNT1          beats delivered on channel 0 / 1 (wrapping)
// ---------------------------------------------------------------------------
module stream_demuxf8_1to2 #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 C,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     I,
  input  logic                 S,
  input  logic                 I_VALID,
  output logic                 I_READY,
  output logic [WIDTH-1:0]     O0,
  output logic [WIDTH-1:0]     O1,
  output logic                 O0_VALID,
  output logic                 O1_VALID,
  input  logic                 O0_READY,
  input  logic                 O1_READY,
  input  logic                 CLR_CNT,
  output logic [CNT_WIDTH-1:0] CNT0,
  output logic [CNT_WIDTH-1:0] CNT1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Counter step with natural wrap from all-ones back to zero.
  function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] cnt);
    return cnt + CNT_ONE;
  endfunction

  logic [WIDTH-1:0]     data0_p1, data1_p1;
  logic                 vld0_p1, vld1_p1;
  logic [CNT_WIDTH-1:0] cnt0_p1, cnt1_p1;

  logic acc_p0, acc0_p0, acc1_p0;
  logic take0_p1, take1_p1;

  // ---- Stage p0: input acceptance ----
  // Readiness looks only at the channel the current beat is aimed at, so a
  // stall on the other channel never back-pressures this beat.
  always_comb begin
    I_READY = RST_N & (S ? (~vld1_p1 | O1_READY) : (~vld0_p1 | O0_READY));
  end

  assign acc_p0   = I_VALID & I_READY;
  assign acc0_p0  = acc_p0 & ~S;
  assign acc1_p0  = acc_p0 &  S;
  assign take0_p1 = vld0_p1 & O0_READY;
  assign take1_p1 = vld1_p1 & O1_READY;

  // ---- Stage p1: per-channel holding registers and counters ----
  always_ff @(posedge C) begin
    if (!RST_N) begin
      vld0_p1  <= 1'b0;
      vld1_p1  <= 1'b0;
      data0_p1 <= '0;
      data1_p1 <= '0;
      cnt0_p1  <= '0;
      cnt1_p1  <= '0;
    end else begin
      // A load keeps the channel full; otherwise a taken beat empties it.
      vld0_p1 <= acc0_p0 | (vld0_p1 & ~O0_READY);
      vld1_p1 <= acc1_p0 | (vld1_p1 & ~O1_READY);
      // Data only changes on a load; an empty channel keeps its last value.
      if (acc0_p0) data0_p1 <= I;
      if (acc1_p0) data1_p1 <= I;
      // Clear takes priority over a same-cycle delivery.
      if (CLR_CNT) begin
        cnt0_p1 <= '0;
        cnt1_p1 <= '0;
      end else begin
        if (take0_p1) cnt0_p1 <= cnt_step(cnt0_p1);
        if (take1_p1) cnt1_p1 <= cnt_step(cnt1_p1);
      end
    end
  end

  assign O0       = data0_p1;
  assign O1       = data1_p1;
  assign O0_VALID = vld0_p1;
  assign O1_VALID = vld1_p1;
  assign CNT0     = cnt0_p1;
  assign CNT1     = cnt1_p1;

endmodule

// File: tb/tb_stream_demuxf8_1to2.sv
// ---------------------------------------------------------------------------
// tb_stream_demuxf8_1to2
//
// Directed and randomized bench for stream_demuxf8_1to2 (CNT_WIDTH=4 so the
// counter wrap is reachable). A queue-based reference model tracks the beats
// held per channel and the number of deliveries.
// ---------------------------------------------------------------------------
module tb_stream_demuxf8_1to2;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          C = 1'b0;
  logic          RST_N = 1'b0;
  logic [W-1:0]  I = '0;
  logic          S = 1'b0;
  logic          I_VALID = 1'b0;
  logic          I_READY;
  logic [W-1:0]  O0, O1;
  logic          O0_VALID, O1_VALID;
  logic          O0_READY = 1'b0;
  logic          O1_READY = 1'b0;
  logic          CLR_CNT = 1'b0;
  logic [CW-1:0] CNT0, CNT1;

  stream_demuxf8_1to2 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .C(C), .RST_N(RST_N), .I(I), .S(S), .I_VALID(I_VALID), .I_READY(I_READY),
    .O0(O0), .O1(O1), .O0_VALID(O0_VALID), .O1_VALID(O1_VALID),
    .O0_READY(O0_READY), .O1_READY(O1_READY), .CLR_CNT(CLR_CNT),
    .CNT0(CNT0), .CNT1(CNT1)
  );

  always #5 C = ~C;

  // Reference model: beats waiting in each channel, last loaded data,
  // delivery counts modulo 2^CW.
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] last0 = '0, last1 = '0;
  int           c0 = 0, c1 = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic cyc();
    logic exp_rdy, acc, pop0, pop1;
    @(negedge C);
    exp_rdy = RST_N && (S ? (q1.size() == 0 || O1_READY) : (q0.size() == 0 || O0_READY));
    chk("i_ready", I_READY, exp_rdy);
    acc  = I_VALID && exp_rdy;
    pop0 = O0_READY && q0.size() != 0;
    pop1 = O1_READY && q1.size() != 0;
    @(posedge C);
    #1;
    if (!RST_N) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      c0 = 0; c1 = 0;
    end else begin
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (CLR_CNT) begin
        c0 = 0; c1 = 0;
      end else begin
        c0 = (c0 + int'(pop0)) % (1 << CW);
        c1 = (c1 + int'(pop1)) % (1 << CW);
      end
      if (acc && !S) begin q0.push_back(I); last0 = I; end
      if (acc &&  S) begin q1.push_back(I); last1 = I; end
    end
    chk("o0_valid", O0_VALID, q0.size() != 0);
    chk("o1_valid", O1_VALID, q1.size() != 0);
    chk("o0_data",  O0, last0);
    chk("o1_data",  O1, last1);
    chk("cnt0",     CNT0, c0);
    chk("cnt1",     CNT1, c1);
  endtask

  task automatic drv(input logic v, input logic s, input logic [W-1:0] d,
                     input logic r0, input logic r1, input logic clr, input logic rstn);
    I_VALID = v; S = s; I = d;
    O0_READY = r0; O1_READY = r1; CLR_CNT = clr; RST_N = rstn;
    cyc();
  endtask

  initial begin
    // Reset held with a beat offered
    for (int k = 0; k < 3; k++) drv(1, 0, 8'hA5, 1, 1, 0, 0);
    chk("rst_i_ready_low", I_READY, 1'b0);

    // First beat after release
    drv(1, 0, 8'hA5, 0, 0, 0, 1);
    chk("first_beat_o0", O0, 8'hA5);
    chk("first_beat_vld", O0_VALID, 1'b1);
    drv(0, 0, 8'h00, 1, 1, 1, 1);

    // Full-rate alternating streaming
    for (int k = 1; k <= 8; k++) drv(1, 1'((k - 1) % 2), 8'(k), 1, 1, 0, 1);
    drv(0, 0, 8'h00, 1, 1, 0, 1);
    chk("stream_cnt0", CNT0, 4);
    chk("stream_cnt1", CNT1, 4);

    // Independent stall on channel 1
    drv(0, 0, 8'h00, 1, 1, 1, 1);
    drv(1, 1, 8'h11, 1, 0, 0, 1);
    drv(1, 0, 8'h22, 1, 0, 0, 1);
    drv(1, 0, 8'h33, 1, 0, 0, 1);
    chk("stall_o1_held", O1, 8'h11);
    drv(1, 1, 8'h44, 1, 0, 0, 1);
    drv(0, 0, 8'h00, 1, 1, 0, 1);
    chk("stall_cnt1", CNT1, 1);
    chk("stall_cnt0", CNT0, 2);

    // Pass-through on a full channel
    drv(1, 0, 8'h40, 0, 1, 0, 1);
    drv(1, 0, 8'h41, 1, 1, 0, 1);
    chk("pass_o0", O0, 8'h41);
    chk("pass_vld", O0_VALID, 1'b1);
    drv(0, 0, 8'h00, 1, 1, 0, 1);

    // Counter wrap and clear priority
    drv(0, 0, 8'h00, 1, 1, 1, 1);
    for (int k = 0; k < 17; k++) drv(1, 0, 8'(8'h80 + k), 1, 1, 0, 1);
    drv(0, 0, 8'h00, 1, 1, 0, 1);
    chk("wrap_cnt0", CNT0, 1);
    drv(1, 0, 8'h55, 0, 1, 0, 1);
    drv(0, 0, 8'h00, 1, 1, 1, 1);
    chk("clr_wins_cnt0", CNT0, 0);

    // Reset while both channels are full and stalled
    drv(1, 0, 8'h66, 0, 0, 0, 1);
    drv(1, 1, 8'h77, 0, 0, 0, 1);
    drv(0, 0, 8'h00, 0, 0, 0, 0);
    chk("midrst_o0_vld", O0_VALID, 1'b0);
    chk("midrst_o1_vld", O1_VALID, 1'b0);
    drv(0, 0, 8'h00, 1, 1, 0, 1);
    chk("midrst_cnt0", CNT0, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drv(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 60) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
